// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

  // Responder control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Byte lanes in one storage word.
  localparam int unsigned BYTE_LANES = 4;

  // Error codes. Any non-zero code reports an access error.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  // Classify an access. Byte accesses may use any lane. Word accesses must be lane 0.
  function automatic logic [1:0] access_err(input logic byte_op,
                                            input logic [1:0] lane,
                                            input logic in_range);
    logic [1:0] code;
    code = ERR_NONE;
    if (!byte_op && (lane != 2'b00)) begin
      code = code | ERR_MISALIGN;
    end else begin
      code = code;
    end
    if (!in_range) begin
      code = code | ERR_RANGE;
    end else begin
      code = code;
    end
    return code;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane helper.
// It extracts a zero-extended read lane and merges a store byte into a word.
module byte_lane_unit
  import mem_resp_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic        byte_i,
  output logic [31:0] rdata_o,
  output logic [31:0] new_word_o
);

  logic [7:0] lane_byte_s;

  // Select the addressed little-endian lane. Lane 0 is bits [7:0].
  always_comb begin
    lane_byte_s = 8'h00;
    case (lane_i)
      2'd0:    lane_byte_s = old_word_i[7:0];
      2'd1:    lane_byte_s = old_word_i[15:8];
      2'd2:    lane_byte_s = old_word_i[23:16];
      2'd3:    lane_byte_s = old_word_i[31:24];
      default: lane_byte_s = 8'h00;
    endcase
  end

  // Produce load data. Byte loads are zero-extended; word loads pass the word through.
  always_comb begin
    rdata_o = 32'h0000_0000;
    if (byte_i) begin
      rdata_o = {24'h00_0000, lane_byte_s};
    end else begin
      rdata_o = old_word_i;
    end
  end

  // Build the stored word. A byte store replaces one lane; a word store replaces all lanes.
  always_comb begin
    new_word_o = old_word_i;
    if (byte_i) begin
      case (lane_i)
        2'd0:    new_word_o[7:0]   = wdata_i[7:0];
        2'd1:    new_word_o[15:8]  = wdata_i[7:0];
        2'd2:    new_word_o[23:16] = wdata_i[7:0];
        2'd3:    new_word_o[31:24] = wdata_i[7:0];
        default: new_word_o        = old_word_i;
      endcase
    end else begin
      new_word_o = wdata_i;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder for the CPU.
// It accepts one request at a time and accesses the word array after LATENCY cycles.
// It holds the response until the requester consumes it.
module data_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_byte_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  localparam int                    IDX_W      = $clog2(MEM_WORDS);
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEM_WORDS * BYTE_LANES);
  localparam logic [3:0]            CNT_INIT   = 4'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  byte_q, byte_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;

  // Storage array. It is deliberately not cleared by reset.
  logic [31:0]           mem_q [MEM_WORDS];
  logic                  mem_we_s;
  logic [IDX_W-1:0]      idx_s;
  logic [31:0]           old_word_s;
  logic [31:0]           lane_rdata_s;
  logic [31:0]           new_word_s;
  logic [1:0]            err_code_s;

  assign idx_s      = addr_q[IDX_W+1:2];
  assign old_word_s = mem_q[idx_s];
  assign err_code_s = access_err(byte_q, addr_q[1:0], addr_q < ADDR_LIMIT);

  byte_lane_unit u_lane (
    .old_word_i (old_word_s),
    .wdata_i    (wdata_q),
    .lane_i     (addr_q[1:0]),
    .byte_i     (byte_q),
    .rdata_o    (lane_rdata_s),
    .new_word_o (new_word_s)
  );

  // Compute the next state: latch the request, count down the latency, then perform the access.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          byte_d  = req_byte_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d    = (err_code_s != ERR_NONE);
          mem_we_s = we_q && (err_code_s == ERR_NONE);
          if ((err_code_s != ERR_NONE) || we_q) begin
            rdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            rdata_d = DATA_WIDTH'(lane_rdata_s);
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
  end

  // Update the control and response registers. An asynchronous reset returns them to idle.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= {DATA_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      rdata_q <= {DATA_WIDTH{1'b0}};
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Commit a store on the WAIT->RESP edge. While reset holds the FSM in IDLE, nothing commits.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= new_word_s;
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard testbench for data_memory_responder.
// It drives a LATENCY=2 instance and a LATENCY=1 instance whose response ready is tied high.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i, req_we_i, req_byte_i, rsp_ready_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, busy_o;
  logic [31:0] rsp_rdata_o;

  logic        l1_req_valid, l1_req_we, l1_req_byte;
  logic [31:0] l1_req_addr, l1_req_wdata;
  logic        l1_req_ready, l1_rsp_valid, l1_rsp_err, l1_busy;
  logic [31:0] l1_rsp_rdata;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [32:0] sb_q[$];
  logic [32:0] sb1_q[$];
  logic        seen  = 1'b0;
  logic        seen1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(.DATA_WIDTH(32), .MEM_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_byte_i(req_byte_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  data_memory_responder #(.DATA_WIDTH(32), .MEM_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n_i(rst_n_i), .req_valid_i(l1_req_valid), .req_ready_o(l1_req_ready),
    .req_we_i(l1_req_we), .req_byte_i(l1_req_byte), .req_addr_i(l1_req_addr),
    .req_wdata_i(l1_req_wdata), .rsp_valid_o(l1_rsp_valid), .rsp_ready_i(1'b1),
    .rsp_rdata_o(l1_rsp_rdata), .rsp_err_o(l1_rsp_err), .busy_o(l1_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for the LATENCY=2 instance. It pops one entry per response.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rsp_valid_o && !seen) begin
      seen = 1'b1;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e[31:0]);
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e[32]});
      end
    end else if (!rsp_valid_o) begin
      seen = 1'b0;
    end
  end

  // Scoreboard monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    logic [32:0] e;
    if (l1_rsp_valid && !seen1) begin
      seen1 = 1'b1;
      if (sb1_q.size() == 0) begin
        chk("l1_sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb1_q.pop_front();
        chk("l1_rsp_rdata", l1_rsp_rdata, e[31:0]);
        chk("l1_rsp_err", {31'd0, l1_rsp_err}, {31'd0, e[32]});
      end
    end else if (!l1_rsp_valid) begin
      seen1 = 1'b0;
    end
  end

  // Issue one request to the LATENCY=2 instance.
  // Check busy, latency and handshake timing. The monitor checks the response data.
  task automatic issue(input logic we, input logic b, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    int n;
    sb_q.push_back({ee, ed});
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_byte_i = b; req_addr_i = a; req_wdata_i = wd;
    n = 0;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("ready_low_after_accept", {31'd0, req_ready_o}, 32'd0);
    chk("busy_after_accept", {31'd0, busy_o}, 32'd1);
    n = 0;
    while (!rsp_valid_o && n < 50) begin @(posedge clk); #1; n++; end
    chk("rsp_latency", n, 32'd2);
    @(posedge clk); #1;
    chk("valid_drop_after_hs", {31'd0, rsp_valid_o}, 32'd0);
    chk("ready_after_hs", {31'd0, req_ready_o}, 32'd1);
  endtask

  logic [31:0] l1_addr [4];
  logic [31:0] l1_wd   [4];
  logic [31:0] l1_exp  [4];
  logic        l1_we   [4];
  logic        l1_byte [4];

  initial begin
    int n;
    int acc;
    int prev_acc;
    rst_n_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_byte_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0; rsp_ready_i = 1'b1;
    l1_req_valid = 1'b0; l1_req_we = 1'b0; l1_req_byte = 1'b0;
    l1_req_addr = 32'h0; l1_req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, req_ready_o}, 32'd1);
    chk("reset_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'h0);
    chk("reset_err", {31'd0, rsp_err_o}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk); rst_n_i = 1'b1;

    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 1'b1, 32'h11, 32'hFFFFFFA5, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);
    issue(1'b0, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    issue(1'b0, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 32'h12, 32'h11111111, 32'h0, 1'b1);
    issue(1'b1, 1'b1, 32'h1003, 32'h22, 32'h0, 1'b1);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);

    // Backpressure: hold the response for 5 cycles while a competing store is presented.
    rsp_ready_i = 1'b0;
    sb_q.push_back({1'b0, 32'hDEADA5EF});
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_byte_i = 1'b0; req_addr_i = 32'h10;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h10; req_wdata_i = 32'h0;
      @(posedge clk); #1;
      chk("bp_valid_held", {31'd0, rsp_valid_o}, 32'd1);
      chk("bp_rdata_held", rsp_rdata_o, 32'hDEADA5EF);
      chk("bp_ready_low", {31'd0, req_ready_o}, 32'd0);
    end
    @(negedge clk);
    req_valid_i = 1'b0; req_we_i = 1'b0; rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready_o}, 32'd1);

    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);
    issue(1'b0, 1'b1, 32'h10, 32'h0, 32'h000000EF, 1'b0);
    issue(1'b0, 1'b1, 32'h11, 32'h0, 32'h000000A5, 1'b0);
    issue(1'b1, 1'b1, 32'h13, 32'hFFFFFF77, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h77ADA5EF, 1'b0);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    // Assert reset asynchronously while a store to 0x20 waits to commit.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_byte_i = 1'b0;
    req_addr_i = 32'h20; req_wdata_i = 32'h12345678;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("rst_mid_busy_before", {31'd0, busy_o}, 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_mid_rdata", rsp_rdata_o, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n_i = 1'b1;
    issue(1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    // Back-to-back traffic on the LATENCY=1 instance.
    l1_addr = '{32'h40, 32'h40, 32'h42, 32'h40};
    l1_wd   = '{32'hCAFE0001, 32'h0, 32'h0000005A, 32'h0};
    l1_exp  = '{32'h0, 32'hCAFE0001, 32'h0, 32'hCA5A0001};
    l1_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
    l1_byte = '{1'b0, 1'b0, 1'b1, 1'b0};
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      l1_req_valid = 1'b1; l1_req_we = l1_we[i]; l1_req_byte = l1_byte[i];
      l1_req_addr = l1_addr[i]; l1_req_wdata = l1_wd[i];
      sb1_q.push_back({1'b0, l1_exp[i]});
      n = 0;
      while (!l1_req_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("l1_ready_timeout", 32'd0, 32'd1);
      acc = cyc;
      @(posedge clk); #1;
      chk("l1_busy_after_accept", {31'd0, l1_busy}, 32'd1);
      chk("l1_valid_not_early", {31'd0, l1_rsp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("l1_rsp_one_cycle", {31'd0, l1_rsp_valid}, 32'd1);
      if (i > 0) chk("l1_accept_period", acc - prev_acc, 32'd3);
      prev_acc = acc;
    end
    @(negedge clk); l1_req_valid = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("sb1_drained", sb1_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog. If it expires, report a failure and stop.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
